// File: rtl/seg7_display_if.sv
// CPU-side IO write port feeding the seven-segment display peripheral.
// The CPU drives the write data, strobe and mode and observes the busy flag.
interface seg7_display_if;
  logic [23:0] io_wdata;
  logic        io_we;
  logic        mode;
  logic        busy;

  modport master (output io_wdata, output io_we, output mode, input busy);
  modport slave  (input io_wdata, input io_we, input mode, output busy);
endinterface

// File: rtl/seg7_display.sv
// Latches CPU writes, converts them to hex or BCD digits (shift-add-3, one bit per cycle)
// and scans them onto an 8-digit common-anode display with leading-zero blanking.
module seg7_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clock,
  input  logic             reset,
  seg7_display_if.slave    io,
  output logic [7:0]       seg_an,
  output logic [7:0]       seg_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int                 PRESC_W   = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [4:0]         LAST_STEP = 5'd23;

  state_t               state_r;
  logic                 busy_r;
  logic                 pend_valid_r;
  logic [23:0]          pend_val_r;
  logic                 pend_mode_r;
  logic [23:0]          bin_r;
  logic [31:0]          bcd_r;
  logic [4:0]           step_r;
  logic [31:0]          disp_r;
  logic [PRESC_W-1:0]   presc_r;
  logic [2:0]           idx_r;
  logic [7:0]           seg_an_r;
  logic [7:0]           seg_out_r;

  logic                 take_s;
  logic [23:0]          take_val_s;
  logic                 take_mode_s;
  logic [55:0]          pair_s;
  logic [31:0]          bcd_shift_s;
  logic [23:0]          bin_shift_s;
  logic                 last_step_s;
  logic [31:0]          disp_next_s;
  logic [PRESC_W-1:0]   presc_next_s;
  logic [2:0]           idx_next_s;

  function automatic logic [31:0] add3_all(input logic [31:0] bcd);
    logic [31:0] res;
    res = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      4'hF:    g = 8'h8E;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [7:0] digit_glyph(input logic [31:0] disp, input logic [2:0] idx);
    logic [31:0] upper;
    logic [7:0]  g;
    upper = disp >> {idx, 2'b00};
    if ((idx != 3'd0) && (upper == 32'd0)) begin
      g = 8'hFF;
    end else begin
      g = hex_glyph(upper[3:0]);
    end
    return g;
  endfunction

  // Next-state datapath: write source selection, BCD step, display and scan updates.
  always_comb begin
    take_s       = 1'b0;
    take_val_s   = 24'd0;
    take_mode_s  = 1'b0;
    pair_s       = {add3_all(bcd_r), bin_r} << 1;
    bcd_shift_s  = pair_s[55:24];
    bin_shift_s  = pair_s[23:0];
    last_step_s  = (state_r == CONV) && (step_r == LAST_STEP);
    disp_next_s  = disp_r;
    presc_next_s = presc_r;
    idx_next_s   = idx_r;

    if (state_r == IDLE) begin
      if (io.io_we) begin
        take_s      = 1'b1;
        take_val_s  = io.io_wdata;
        take_mode_s = io.mode;
      end else if (pend_valid_r) begin
        take_s      = 1'b1;
        take_val_s  = pend_val_r;
        take_mode_s = pend_mode_r;
      end else begin
        take_s      = 1'b0;
      end
    end else begin
      take_s = 1'b0;
    end

    if (take_s && !take_mode_s) begin
      disp_next_s = {8'h00, take_val_s};
    end else if (last_step_s) begin
      disp_next_s = bcd_shift_s;
    end else begin
      disp_next_s = disp_r;
    end

    if (presc_r == PRESC_MAX) begin
      presc_next_s = '0;
      idx_next_s   = idx_r + 3'd1;
    end else begin
      presc_next_s = presc_r + PRESC_ONE;
      idx_next_s   = idx_r;
    end
  end

  // Control FSM, conversion registers, pending buffer, display and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_val_r   <= 24'd0;
      pend_mode_r  <= 1'b0;
      bin_r        <= 24'd0;
      bcd_r        <= 32'd0;
      step_r       <= 5'd0;
      disp_r       <= 32'd0;
      presc_r      <= '0;
      idx_r        <= 3'd0;
      seg_an_r     <= 8'hFE;
      seg_out_r    <= 8'hC0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            pend_valid_r <= 1'b0;
            if (take_mode_s) begin
              bin_r   <= take_val_s;
              bcd_r   <= 32'd0;
              step_r  <= 5'd0;
              busy_r  <= 1'b1;
              state_r <= CONV;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          bcd_r  <= bcd_shift_s;
          bin_r  <= bin_shift_s;
          step_r <= step_r + 5'd1;
          if (io.io_we) begin
            pend_valid_r <= 1'b1;
            pend_val_r   <= io.io_wdata;
            pend_mode_r  <= io.mode;
          end else begin
            pend_valid_r <= pend_valid_r;
          end
          if (last_step_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= CONV;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase

      disp_r    <= disp_next_s;
      presc_r   <= presc_next_s;
      idx_r     <= idx_next_s;
      seg_an_r  <= ~(8'h01 << idx_next_s);
      seg_out_r <= digit_glyph(disp_next_s, idx_next_s);
    end
  end

  assign io.busy = busy_r;
  assign seg_an  = seg_an_r;
  assign seg_out = seg_out_r;

endmodule

// File: tb/tb_seg7_display.sv
// Self-checking bench: a digit-level model (arithmetic hex/decimal digits, blanking, scan position)
// predicts seg_an/seg_out/busy every sampled cycle.
module tb_seg7_display;
  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seg_an;
  logic [7:0] seg_out;

  seg7_display_if bus ();

  seg7_display #(.SCAN_DIV(SD)) dut (
    .clock   (clock),
    .reset   (reset),
    .io      (bus),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int md [8];
  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic int cur_idx();
    return (cyc / SD) % 8;
  endfunction

  function automatic logic [7:0] exp_an();
    logic [7:0] a;
    a = 8'h01 << cur_idx();
    return ~a;
  endfunction

  function automatic logic [7:0] exp_seg(int idx);
    int msd = 0;
    for (int i = 0; i < 8; i++) if (md[i] != 0) msd = i;
    if (idx > msd) return 8'hFF;
    return glyph_tab[md[idx]];
  endfunction

  function automatic void model_hex(int v);
    for (int i = 0; i < 8; i++) md[i] = (v >> (4 * i)) & 15;
  endfunction

  function automatic void model_dec(int v);
    int r = v;
    for (int i = 0; i < 8; i++) begin
      md[i] = r % 10;
      r = r / 10;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.io_we = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
    model_hex(0);
  endtask

  task automatic write(input int v, input logic m);
    bus.io_wdata = v[23:0];
    bus.mode     = m;
    bus.io_we    = 1'b1;
    tick();
    bus.io_we    = 1'b0;
  endtask

  // Walks 32 cycles comparing every scanned digit against the model.
  task automatic scan_check(input string name, input logic exp_busy);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (seg_an !== exp_an() || seg_out !== exp_seg(cur_idx()) || bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL %s cyc=%0d: an=%h seg=%h busy=%b, required an=%h seg=%h busy=%b",
                 name, cyc, seg_an, seg_out, bus.busy, exp_an(), exp_seg(cur_idx()), exp_busy);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (seg_an !== 8'hFE || seg_out !== 8'hC0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h busy=%b, required FE C0 0", seg_an, seg_out, bus.busy);
    end
    for (int k = 0; k < 36; k++) begin
      checks++;
      if (seg_an !== exp_an()) begin
        errors++;
        $display("FAIL scan_walk cyc=%0d: an=%h, required %h", cyc, seg_an, exp_an());
      end
      tick();
    end
  endtask

  task automatic test_hex();
    int vals [4];
    vals[0] = 24'h00ABCD;
    vals[1] = int'($urandom_range(0, 24'hFFFFFF));
    vals[2] = int'($urandom_range(0, 255));
    vals[3] = 0;
    for (int t = 0; t < 4; t++) begin
      write(vals[t], 1'b0);
      model_hex(vals[t]);
      scan_check("hex_digits", 1'b0);
    end
  endtask

  // Decimal write: old digits and busy=1 for 24 cycles, then new digits with busy=0.
  task automatic test_decimal();
    int vals [4];
    vals[0] = 24'hFFFFFF;
    vals[1] = 0;
    vals[2] = int'($urandom_range(0, 24'hFFFFFF));
    vals[3] = int'($urandom_range(0, 9999));
    for (int t = 0; t < 4; t++) begin
      write(vals[t], 1'b1);
      for (int c = 1; c <= 24; c++) begin
        checks++;
        if (bus.busy !== 1'b1 || seg_out !== exp_seg(cur_idx())) begin
          errors++;
          $display("FAIL dec_busy N+%0d: busy=%b seg=%h, required 1 %h", c, bus.busy, seg_out, exp_seg(cur_idx()));
        end
        tick();
      end
      model_dec(vals[t]);
      scan_check("dec_digits", 1'b0);
    end
  endtask

  task automatic test_pending();
    write(1234, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      checks++;
      if (bus.busy !== 1'b1 || seg_out !== exp_seg(cur_idx())) begin
        errors++;
        $display("FAIL pend_conv N+%0d: busy=%b seg=%h, required 1 %h", c, bus.busy, seg_out, exp_seg(cur_idx()));
      end
      bus.io_we    = (c == 10 || c == 12);
      bus.mode     = 1'b0;
      bus.io_wdata = (c == 12) ? 24'h000007 : 24'h000005;
      tick();
    end
    bus.io_we = 1'b0;
    model_dec(1234);
    checks++;
    if (bus.busy !== 1'b0 || seg_out !== exp_seg(cur_idx())) begin
      errors++;
      $display("FAIL pend_1234_window: busy=%b seg=%h, required 0 %h", bus.busy, seg_out, exp_seg(cur_idx()));
    end
    tick();
    model_hex(7);
    scan_check("pend_hex7", 1'b0);

    // io_we in the last conversion cycle: queued, then converted after one idle cycle.
    write(4321, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL last_step_busy N+%0d: busy=%b, required 1", c, bus.busy);
      end
      bus.io_we    = (c == 24);
      bus.mode     = 1'b1;
      bus.io_wdata = 24'd987654;
      tick();
    end
    bus.io_we = 1'b0;
    model_dec(4321);
    checks++;
    if (bus.busy !== 1'b0 || seg_out !== exp_seg(cur_idx())) begin
      errors++;
      $display("FAIL last_step_idle: busy=%b seg=%h, required 0 %h", bus.busy, seg_out, exp_seg(cur_idx()));
    end
    tick();
    for (int c = 26; c <= 49; c++) begin
      checks++;
      if (bus.busy !== 1'b1 || seg_out !== exp_seg(cur_idx())) begin
        errors++;
        $display("FAIL second_conv N+%0d: busy=%b seg=%h, required 1 %h", c, bus.busy, seg_out, exp_seg(cur_idx()));
      end
      tick();
    end
    model_dec(987654);
    scan_check("second_dec", 1'b0);
  endtask

  // A write in the idle cycle supersedes the queued entry.
  task automatic test_back_to_back();
    write(24'h00A1B2, 1'b0);
    model_hex(24'h00A1B2);
    checks++;
    if (seg_out !== exp_seg(cur_idx())) begin
      errors++;
      $display("FAIL b2b_first: seg=%h, required %h", seg_out, exp_seg(cur_idx()));
    end
    write(24'h3C0000, 1'b0);
    model_hex(24'h3C0000);
    scan_check("b2b_second", 1'b0);

    write(55555, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      bus.io_we    = (c == 5);
      bus.mode     = 1'b0;
      bus.io_wdata = 24'h0000EE;
      tick();
    end
    model_dec(55555);
    checks++;
    if (bus.busy !== 1'b0 || seg_out !== exp_seg(cur_idx())) begin
      errors++;
      $display("FAIL discard_window: busy=%b seg=%h, required 0 %h", bus.busy, seg_out, exp_seg(cur_idx()));
    end
    write(24'h000F00, 1'b0);
    model_hex(24'h000F00);
    scan_check("discard_pending", 1'b0);
  endtask

  task automatic test_reset_mid();
    write(999999, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      bus.io_we = (c == 3);
      bus.mode  = 1'b0;
      bus.io_wdata = 24'h000123;
      tick();
    end
    bus.io_we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    model_hex(0);
    checks++;
    if (bus.busy !== 1'b0 || seg_an !== 8'hFE || seg_out !== 8'hC0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b an=%h seg=%h, required 0 FE C0", bus.busy, seg_an, seg_out);
    end
    scan_check("reset_mid_quiet", 1'b0);
    scan_check("reset_mid_quiet2", 1'b0);
  endtask

  initial begin
    bus.io_we    = 1'b0;
    bus.io_wdata = 24'd0;
    bus.mode     = 1'b0;
    test_reset();
    test_hex();
    test_decimal();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_display.md
# seg7_display

Memory-mapped output peripheral driven by the CPU's 24-bit IO write port. It latches each value the processor writes and converts it to hexadecimal or decimal digits; decimal conversion is sequential (shift-add-3, one bit per cycle). It then time-multiplexes the result onto an 8-digit common-anode seven-segment display. It sits directly downstream of the CPU top, consuming its IO write data together with the decoded write strobe.

## Interface
- SCAN_DIV, default 50000: clock cycles each digit stays enabled; must be ≥ 2.
- clock  in  1  system clock (the CPU's clk_out1 domain).
- reset  in  1  synchronous, active-high reset.
- io_wdata  in  24  value written by the CPU; unsigned.
- io_we  in  1  single-cycle write strobe; io_wdata and mode are sampled when high.
- mode  in  1  0 = hexadecimal display, 1 = decimal display; sampled with io_we.
- busy  out  1  high while a decimal conversion is in progress.
- seg_an  out  8  digit enables, active low, one-hot; bit i = digit i (digit 0 = rightmost).
- seg_out  out  8  segments, active low, {dp,g,f,e,d,c,b,a}; dp always 1.

## Operation
- States: IDLE, CONV.
- Write buffer: holds one pending {value, mode} entry plus a valid flag. The last write wins.
- IDLE, io_we=1:
  - mode=0: the display register loads the six nibbles directly. Digits 6 and 7 are always zero-valued.
  - mode=1: latch the value, clear the 32-bit BCD accumulator, set the step count to 0, go to CONV.
  - Any pending entry is discarded, because the newer write supersedes it.
- IDLE, io_we=0, pending valid: process the pending entry exactly as a write, then clear the flag.
- CONV: each cycle, add 3 to every BCD nibble that is ≥ 5, then shift the {BCD, binary} pair left by one bit.
  - After step 24, load the display register with the 8 BCD digits and return to IDLE.
  - io_we during CONV writes the pending buffer only.
- Leading-zero blanking applies in both modes:
  - Digits above the most significant non-zero digit show seg_out = 8'hFF, with their anode still enabled.
  - Value 0 shows "0" on digit 0 only.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→7, then wraps to 0.
  - The scan runs continuously and is independent of conversion.
  - seg_an = ~(8'b1 << index).
  - seg_out = glyph of the display digit at index.
- Glyphs (active low), 0-F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- The display register is only ever replaced atomically. Partial conversions are never visible.

## Timing
- Reset values:
  - seg_an = 8'hFE, seg_out = 8'hC0 (display register = 0).
  - busy = 0, state IDLE, pending cleared.
  - Prescaler = 0, digit index = 0.
- Hex write with io_we in cycle N: new digits are visible from cycle N+1. busy stays 0.
- Decimal write with io_we in cycle N:
  - busy = 1 in cycles N+1..N+24.
  - The new digits and busy = 0 appear from cycle N+25.
- Pending after CONV: the entry is taken at the end of cycle N+25, the single IDLE cycle.
  - If hex, it is visible from N+26.
  - If decimal, busy is high again for N+26..N+49.
- io_we in the last CONV cycle (N+24) goes to pending and is processed in cycle N+25.
- Reset asserted mid-conversion:
  - The conversion is aborted and pending is cleared.
  - The display returns to 0 and busy = 0 in the next cycle.
- The digit index advances exactly once per SCAN_DIV cycles. The first advance is at cycle SCAN_DIV after reset release.

## Test plan
- Reset, SCAN_DIV=4 -> seg_an=FE, seg_out=C0, busy=0. Then seg_an steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, changing every 4 cycles.
- Hex write 24'h00ABCD -> next cycle, digits 0..3 show A1, C6, 83, 88; digits 4..7 show FF; busy never rises.
- Decimal write 24'hFFFFFF -> busy high exactly 24 cycles; digits 0..7 then show 5, 1, 2, 7, 7, 7, 6, 1 (92, F9, A4, F8, F8, F8, 82, F9).
- Decimal write 1234 at cycle N, hex 0x5 at N+10, hex 0x7 at N+12 -> "1234" visible in cycle N+25 only; "7" visible from N+26; 0x5 never displayed.
- Decimal write 0 -> after 24 busy cycles, digit 0 = C0, digits 1..7 = FF.
- Decimal write 999999, reset pulsed at CONV step 12 -> busy=0 and display = 0 in the following cycle; no later update occurs.
